// File: rtl/wb_master_pkg.sv
// Shared types and sizing helpers for the Wishbone command master.
package wb_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Values for the default configuration; instances size themselves with the helpers below.
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;
  localparam int SEL_W       = DATA_W_DEF / 8;
  localparam int TO_W        = $clog2(TIMEOUT_DEF + 1);

  function automatic int sel_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int to_w(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// BUS-phase watchdog: counts cycles while enabled and flags the last allowed cycle.
module wb_timeout_ctr
  import wb_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = to_w(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                  cnt_d = '0;
    else if (enable && !expired) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: one valid/ready command -> one WB cycle -> one response.
// Optional BUS-phase timeout is built only when WB_TIMEOUT_EN is defined.
module wb_cmd_master
  import wb_master_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [ADDR_W-1:0]   cmd_adr,
  input  logic [DATA_W-1:0]   cmd_dat,
  input  logic [DATA_W/8-1:0] cmd_sel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_dat,
  output logic                rsp_err,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [DATA_W/8-1:0] wbm_sel_o,
  output logic [ADDR_W-1:0]   wbm_adr_o,
  output logic [DATA_W-1:0]   wbm_dat_o,
  input  logic [DATA_W-1:0]   wbm_dat_i,
  input  logic                wbm_ack_i,
  input  logic                wbm_err_i,
  output logic                busy
);

  localparam int SW = sel_w(DATA_W);

  state_e            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;
  logic              rsp_err_q, rsp_err_d;
  logic              accept, to_expired;

  assign accept = cmd_valid & cmd_ready_q;

`ifdef WB_TIMEOUT_EN
  wb_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (accept),
    .enable  (state_q == BUS),
    .expired (to_expired)
  );
`else
  // No watchdog: constant-false tie-off that still references the parameter.
  assign to_expired = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = BUS;
        cyc_d   = 1'b1;
        we_d    = cmd_we;
        sel_d   = cmd_sel;
        adr_d   = cmd_adr;
        dat_d   = cmd_dat;
      end
      BUS: if (wbm_ack_i || wbm_err_i || to_expired) begin
        // err beats ack; a timeout only counts when the slave stayed silent
        state_d     = RESP;
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = wbm_err_i | ~wbm_ack_i;
        rsp_dat_d   = (wbm_ack_i && !wbm_err_i && !we_q) ? wbm_dat_i : '0;
      end
      RESP: if (rsp_ready) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != IDLE);

endmodule
